// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard control for a 5-stage pipeline.
// Shadows the EX/MEM/WB register specifiers and selects the bypass source.
module forward_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             load_use_stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // _p0 = EX shadow, _p1 = MEM shadow, _p2 = WB shadow
  logic             r_vld_p0, r_vld_p1, r_vld_p2;
  logic [REG_W-1:0] r_dest_p0, r_dest_p1, r_dest_p2;
  logic             r_regwrite_p0, r_regwrite_p1, r_regwrite_p2;
  logic             r_memread_p0, r_memread_p1, r_memread_p2;
  logic [REG_W-1:0] r_rs_p0, r_rt_p0;

  logic w_stall_raw;
  logic w_unused_wb_memread;

  // Youngest valid producer wins; register 0 is hard-wired and never a source.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = SEL_RF;
    if (r_vld_p0) begin
      if (r_vld_p1 && r_regwrite_p1 && (r_dest_p1 != '0) && (r_dest_p1 == src))
        sel = SEL_MEM;
      else if (r_vld_p2 && r_regwrite_p2 && (r_dest_p2 != '0) && (r_dest_p2 == src))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  assign fwd_a_sel = fwd_sel(r_rs_p0);
  assign fwd_b_sel = fwd_sel(r_rt_p0);

  assign w_stall_raw = r_vld_p0 && r_memread_p0 && (r_dest_p0 != '0) && id_valid &&
                       ((r_dest_p0 == id_rs) || (r_dest_p0 == id_rt));
  assign load_use_stall = w_stall_raw && !hold && !reset;

  // WB memread is shadowed for completeness but no rule consumes it.
  assign w_unused_wb_memread = r_memread_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0      <= 1'b0;
      r_dest_p0     <= '0;
      r_regwrite_p0 <= 1'b0;
      r_memread_p0  <= 1'b0;
      r_rs_p0       <= '0;
      r_rt_p0       <= '0;
      r_vld_p1      <= 1'b0;
      r_dest_p1     <= '0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_vld_p2      <= 1'b0;
      r_dest_p2     <= '0;
      r_regwrite_p2 <= 1'b0;
      r_memread_p2  <= 1'b0;
    end else if (!hold) begin
      // ID -> EX: squashed or stalled slots enter EX as an all-zero bubble
      if (flush || load_use_stall) begin
        r_vld_p0      <= 1'b0;
        r_dest_p0     <= '0;
        r_regwrite_p0 <= 1'b0;
        r_memread_p0  <= 1'b0;
        r_rs_p0       <= '0;
        r_rt_p0       <= '0;
      end else begin
        r_vld_p0      <= id_valid;
        r_dest_p0     <= id_dest;
        r_regwrite_p0 <= id_regwrite;
        r_memread_p0  <= id_memread;
        r_rs_p0       <= id_rs;
        r_rt_p0       <= id_rt;
      end
      // EX -> MEM
      r_vld_p1      <= r_vld_p0;
      r_dest_p1     <= r_dest_p0;
      r_regwrite_p1 <= r_regwrite_p0;
      r_memread_p1  <= r_memread_p0;
      // MEM -> WB
      r_vld_p2      <= r_vld_p1;
      r_dest_p2     <= r_dest_p1;
      r_regwrite_p2 <= r_regwrite_p1;
      r_memread_p2  <= r_memread_p1;
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: an instruction-history model checked every
// cycle, plus literal expectations for the classic hazard sequences.
module tb_forward_ctrl;
  localparam int RW = 5;

  logic          clk;
  logic          reset, hold, flush;
  logic          id_valid, id_regwrite, id_memread;
  logic [RW-1:0] id_rs, id_rt, id_dest;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          load_use_stall;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  forward_ctrl #(.REG_W(RW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rs, rt, dest;
    logic          rw, mr;
  } ins_t;

  // History of what occupied EX, newest first: [0]=EX, [1]=MEM, [2]=WB.
  ins_t pipe[$];

  function automatic logic [1:0] m_sel(input logic [RW-1:0] r);
    if (!pipe[0].v) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (pipe[age].v && pipe[age].rw && pipe[age].dest != 0 && pipe[age].dest == r)
        return (age == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    if (reset || hold) return 1'b0;
    return pipe[0].v && pipe[0].mr && pipe[0].dest != 0 && id_valid &&
           (pipe[0].dest == id_rs || pipe[0].dest == id_rt);
  endfunction

  always @(posedge clk) begin
    ins_t n;
    if (reset) begin
      pipe = '{};
      repeat (3) pipe.push_back('0);
      chk_en = 1'b1;
    end else if (!hold) begin
      if (flush || m_stall()) n = '0;
      else n = '{v: id_valid, rs: id_rs, rt: id_rt, dest: id_dest, rw: id_regwrite, mr: id_memread};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] ea, eb;
      logic es;
      ea = m_sel(pipe[0].rs);
      eb = m_sel(pipe[0].rt);
      es = m_stall();
      checks++;
      if (fwd_a_sel !== ea || fwd_b_sel !== eb || load_use_stall !== es) begin
        errors++;
        $display("FAIL model @%0t: got a=%b b=%b stall=%b, want a=%b b=%b stall=%b",
                 $time, fwd_a_sel, fwd_b_sel, load_use_stall, ea, eb, es);
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] a, input logic [1:0] b, input logic s);
    checks++;
    if (fwd_a_sel !== a || fwd_b_sel !== b || load_use_stall !== s) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b stall=%b, want a=%b b=%b stall=%b",
               name, fwd_a_sel, fwd_b_sel, load_use_stall, a, b, s);
    end
  endtask

  task automatic issue(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [RW-1:0] dest, input logic rw, input logic mr);
    @(posedge clk);
    #1;
    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
    id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_regwrite = 1'b0; id_memread = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_high", 2'b00, 2'b00, 1'b0);

    // add $3 ; sub $5,$3,$4
    issue(1, 5'd1, 5'd2, 5'd3, 1, 0);
    #1 chk("after_reset", 2'b00, 2'b00, 1'b0);
    issue(1, 5'd3, 5'd4, 5'd5, 1, 0);
    nop();
    #1 chk("fwd_mem_a", 2'b01, 2'b00, 1'b0);
    drain();

    // add $3 ; nop ; or $6,$1,$3
    issue(1, 5'd1, 5'd2, 5'd3, 1, 0);
    nop();
    issue(1, 5'd1, 5'd3, 5'd6, 1, 0);
    nop();
    #1 chk("fwd_wb_b", 2'b00, 2'b10, 1'b0);
    drain();

    // add $3 ; add $3 ; and $7,$3,$3
    issue(1, 5'd1, 5'd2, 5'd3, 1, 0);
    issue(1, 5'd1, 5'd2, 5'd3, 1, 0);
    issue(1, 5'd3, 5'd3, 5'd7, 1, 0);
    nop();
    #1 chk("mem_priority", 2'b01, 2'b01, 1'b0);
    drain();

    // lw $2 ; add $4,$2,$1 (ID is held during the stall)
    issue(1, 5'd1, 5'd0, 5'd2, 1, 1);
    issue(1, 5'd2, 5'd1, 5'd4, 1, 0);
    #1 chk("lu_stall", 2'b00, 2'b00, 1'b1);
    issue(1, 5'd2, 5'd1, 5'd4, 1, 0);
    #1 chk("lu_bubble", 2'b00, 2'b00, 1'b0);
    nop();
    #1 chk("lu_fwd_wb", 2'b10, 2'b00, 1'b0);
    drain();

    // writes to $0 never forward or stall
    issue(1, 5'd1, 5'd0, 5'd0, 1, 0);
    issue(1, 5'd0, 5'd0, 5'd8, 1, 0);
    nop();
    #1 chk("r0_mem", 2'b00, 2'b00, 1'b0);
    issue(1, 5'd1, 5'd0, 5'd0, 1, 1);
    issue(1, 5'd0, 5'd0, 5'd8, 1, 0);
    #1 chk("r0_stall", 2'b00, 2'b00, 1'b0);
    drain();

    // flushed producer is squashed
    issue(1, 5'd1, 5'd2, 5'd11, 1, 0);
    flush = 1'b1;
    issue(1, 5'd11, 5'd0, 5'd12, 1, 0);
    nop();
    #1 chk("flush_squash", 2'b00, 2'b00, 1'b0);
    drain();

    // pending stall, hold for 3 cycles, then reset mid-stall
    issue(1, 5'd1, 5'd0, 5'd9, 1, 1);
    issue(1, 5'd9, 5'd2, 5'd10, 1, 0);
    #1 chk("hold_pre", 2'b00, 2'b00, 1'b1);
    hold = 1'b1;
    #1 chk("hold_forces0", 2'b00, 2'b00, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("hold_frozen", 2'b00, 2'b00, 1'b0);
    end
    hold = 1'b0;
    #1 chk("hold_release", 2'b00, 2'b00, 1'b1);
    reset = 1'b1;
    #1 chk("reset_forces0", 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_mid_stall", 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    #1 chk("post_reset_run", 2'b00, 2'b00, 1'b0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
